pair_match_ctrl: RTL and testbench
==================================

PAIR_MATCH_CTRL -- requirements
Module: pair_match_ctrl

Interface
REQ-001 Parameter X_ORIGIN, default 100, sets the x of the tile grid's left edge in pixels.
REQ-002 Parameter Y_ORIGIN, default 100, sets the y of the tile grid's top edge in pixels.
REQ-003 Parameter A_SIDE, default 100, sets the tile width in pixels.
REQ-004 Parameter B_SIDE, default 100, sets the tile height in pixels.
REQ-005 Parameter GAP, default 20, sets the spacing between adjacent tiles, both axes.
REQ-006 Parameter HOLD_CYCLES, default 65_000_000, sets how many clocks a mismatched pair stays shown.
REQ-007 clk  input  1  is the single system clock; all logic is on its rising edge.
REQ-008 rst  input  1  is a synchronous, active-high reset.
REQ-009 MouseLeft  input  1  is the left-button level.
REQ-010 xpos  input  12  is the cursor x.
REQ-011 ypos  input  12  is the cursor y.
REQ-012 pair_id  input  48  holds a 3-bit image id per tile, with tile k at bits [3k+2:3k].
REQ-013 show_mask  output  16  sets bit k = tile k drawn face-up.
REQ-014 matched_mask  output  16  sets bit k = tile k permanently solved.
REQ-015 pairs_found  output  4  counts solved pairs, 0..8.
REQ-016 mismatch  output  1  is high for the full HOLD period.
REQ-017 game_done  output  1  is high when all 8 pairs are solved.

Function
REQ-018 Tile grid is 4x4; tile index = row*4+col.
REQ-019 A tile is hit when X_ORIGIN+col*(A_SIDE+GAP) <= xpos <= X_ORIGIN+col*(A_SIDE+GAP)+A_SIDE and the same rule holds for ypos with Y_ORIGIN and B_SIDE; both bounds are inclusive.
REQ-020 A cursor position in a gap or outside the grid is no hit.
REQ-021 A click is a rising edge of MouseLeft, taken against a registered previous sample; holding the button generates no further clicks.
REQ-022 A valid click is a click that hits a tile whose show_mask and matched_mask bits are both 0, arriving in state IDLE or ONE; all other clicks are ignored.
REQ-023 FSM states are IDLE, ONE, CHECK, HOLD and DONE.
REQ-024 IDLE: a valid click in cycle N stores the tile index as first, sets its show bit at N+1, and moves to ONE.
REQ-025 ONE: a valid click in cycle N stores the tile as second, sets its show bit at N+1, and moves to CHECK.
REQ-026 A click on the first tile itself is ignored because its show bit is 1.
REQ-027 CHECK lasts 1 cycle and compares pair_id[first] with pair_id[second].
REQ-028 On an id match in CHECK, the next edge sets both matched bits, keeps both show bits at 1, and increments pairs_found.
REQ-029 After a match, the FSM goes to DONE if pairs_found becomes 8, otherwise to IDLE.
REQ-030 On an id mismatch in CHECK, the next edge loads the hold counter with 0 and enters HOLD, with mismatch=1.
REQ-031 HOLD increments the counter each clock; in the cycle the counter equals HOLD_CYCLES-1, both show bits are cleared at the next edge, mismatch drops, and the FSM returns to IDLE.
REQ-032 The total time face-up in HOLD is exactly HOLD_CYCLES clocks.
REQ-033 DONE: game_done=1; all clicks are ignored; only rst exits.
REQ-034 matched_mask bits, once set, are never cleared except by rst.
REQ-035 show_mask is a superset of matched_mask at all times.
REQ-036 A rising edge of MouseLeft in the same cycle as the HOLD expiry is ignored.
REQ-037 The hold counter is 27 bits wide and must not wrap for the default value.
REQ-038 pair_id is sampled only in CHECK; changes at any other time have no effect on a pending comparison.

Reset
REQ-039 When rst=1 at a clock edge, the next state is IDLE with show_mask=0, matched_mask=0, pairs_found=0, mismatch=0, game_done=0, hold counter=0, and the registered MouseLeft=0.
REQ-040 Reset mid-HOLD or in DONE aborts the operation immediately with the same values.
REQ-041 Because the registered MouseLeft resets to 0, a button held through reset release produces one click on the first cycle after reset.

Verification
REQ-042 Single reveal: click at (150,150), tile 0 -> show_mask=0x0001 one cycle after the edge; state ONE.
REQ-043 Match: tiles 0 and 1 have id 3; click (150,150), release, click (270,150) -> show_mask=0x0003, matched_mask=0x0003, pairs_found=1.
REQ-044 Mismatch with HOLD_CYCLES=4: ids 1 and 2 on tiles 0 and 5; click (150,150), then click (270,270) -> mismatch high for exactly 4 cycles, then show_mask=0x0000.
REQ-045 Boundaries: clicks at x=200 (tile 0 edge) -> hit; x=210 (gap) -> ignored; x=99 -> ignored; a click during HOLD -> ignored; a repeat click on tile 0 in ONE -> ignored.
REQ-046 Completion: solve all 8 pairs -> pairs_found=8, game_done=1, matched_mask=0xFFFF; a further click leaves all outputs unchanged.
REQ-047 Reset in HOLD: assert rst on the 2nd HOLD cycle -> all outputs 0 on the next edge; a held button produces one click after release.

Source files
------------

// File: rtl/pair_match_ctrl_if.sv
// Bundles the mouse/cursor inputs and game-state outputs of the pair matching controller.
interface pair_match_ctrl_if;
    logic        MouseLeft;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [47:0] pair_id;
    logic [15:0] show_mask;
    logic [15:0] matched_mask;
    logic [3:0]  pairs_found;
    logic        mismatch;
    logic        game_done;

    modport master (
        output MouseLeft, xpos, ypos, pair_id,
        input  show_mask, matched_mask, pairs_found, mismatch, game_done
    );

    modport slave (
        input  MouseLeft, xpos, ypos, pair_id,
        output show_mask, matched_mask, pairs_found, mismatch, game_done
    );
endinterface

// File: rtl/pair_match_ctrl.sv
// Memory-game controller for a 4x4 tile grid: reveals clicked tiles in pairs,
// locks matching pairs, and shows mismatched pairs for a fixed hold time.
module pair_match_ctrl #(
    parameter int X_ORIGIN    = 100,
    parameter int Y_ORIGIN    = 100,
    parameter int A_SIDE      = 100,
    parameter int B_SIDE      = 100,
    parameter int GAP         = 20,
    parameter int HOLD_CYCLES = 65_000_000
) (
    input  logic             clk,
    input  logic             rst,
    pair_match_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ONE,
        S_CHECK,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [26:0] HOLD_LAST = 27'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] show_q, show_d;
    logic [15:0] matched_q, matched_d;
    logic [3:0]  pairs_q, pairs_d;
    logic [3:0]  first_q, first_d;
    logic [3:0]  second_q, second_d;
    logic [26:0] hold_q, hold_d;
    logic        mouse_q, mouse_d;

    int          x_val;
    int          y_val;
    logic        col_hit;
    logic        row_hit;
    logic [1:0]  col;
    logic [1:0]  row;
    logic        hit;
    logic [3:0]  hit_idx;
    logic        click;
    logic        valid_click;
    logic [2:0]  id_first;
    logic [2:0]  id_second;

    assign x_val = {20'd0, bus.xpos};
    assign y_val = {20'd0, bus.ypos};

    // Descending scan so the lowest column/row wins if GAP is 0 and edges touch.
    always_comb begin
        col_hit = 1'b0;
        col     = 2'd0;
        row_hit = 1'b0;
        row     = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (x_val >= X_ORIGIN + c * (A_SIDE + GAP) &&
                x_val <= X_ORIGIN + c * (A_SIDE + GAP) + A_SIDE) begin
                col_hit = 1'b1;
                col     = 2'(c);
            end
            if (y_val >= Y_ORIGIN + c * (B_SIDE + GAP) &&
                y_val <= Y_ORIGIN + c * (B_SIDE + GAP) + B_SIDE) begin
                row_hit = 1'b1;
                row     = 2'(c);
            end
        end
    end

    assign hit     = col_hit & row_hit;
    assign hit_idx = {row, col};
    assign click   = bus.MouseLeft & ~mouse_q;

    assign valid_click = click & hit & ~show_q[hit_idx] & ~matched_q[hit_idx] &
                         ((state_q == S_IDLE) || (state_q == S_ONE));

    always_comb begin
        id_first  = 3'd0;
        id_second = 3'd0;
        for (int k = 0; k < 16; k++) begin
            if (first_q == 4'(k)) begin
                id_first = bus.pair_id[3*k +: 3];
            end
            if (second_q == 4'(k)) begin
                id_second = bus.pair_id[3*k +: 3];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        show_d    = show_q;
        matched_d = matched_q;
        pairs_d   = pairs_q;
        first_d   = first_q;
        second_d  = second_q;
        hold_d    = hold_q;
        mouse_d   = bus.MouseLeft;

        unique case (state_q)
            S_IDLE: begin
                if (valid_click) begin
                    first_d         = hit_idx;
                    show_d[hit_idx] = 1'b1;
                    state_d         = S_ONE;
                end
            end
            S_ONE: begin
                if (valid_click) begin
                    second_d        = hit_idx;
                    show_d[hit_idx] = 1'b1;
                    state_d         = S_CHECK;
                end
            end
            S_CHECK: begin
                if (id_first == id_second) begin
                    matched_d[first_q]  = 1'b1;
                    matched_d[second_q] = 1'b1;
                    pairs_d             = pairs_q + 4'd1;
                    state_d             = (pairs_q == 4'd7) ? S_DONE : S_IDLE;
                end else begin
                    hold_d  = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                hold_d = hold_q + 27'd1;
                if (hold_q == HOLD_LAST) begin
                    show_d[first_q]  = 1'b0;
                    show_d[second_q] = 1'b0;
                    state_d          = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            show_q    <= '0;
            matched_q <= '0;
            pairs_q   <= '0;
            first_q   <= '0;
            second_q  <= '0;
            hold_q    <= '0;
            mouse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            show_q    <= show_d;
            matched_q <= matched_d;
            pairs_q   <= pairs_d;
            first_q   <= first_d;
            second_q  <= second_d;
            hold_q    <= hold_d;
            mouse_q   <= mouse_d;
        end
    end

    assign bus.show_mask    = show_q;
    assign bus.matched_mask = matched_q;
    assign bus.pairs_found  = pairs_q;
    assign bus.mismatch     = (state_q == S_HOLD);
    assign bus.game_done    = (state_q == S_DONE);
endmodule

// File: tb/tb_pair_match_ctrl.sv
// Self-checking bench for pair_match_ctrl: directed vector table, hand-written
// corner sequences, and randomized play checked against a game-level model.
module tb_pair_match_ctrl;
    localparam int HOLD = 4;
    localparam int X0   = 100;
    localparam int Y0   = 100;
    localparam int AS   = 100;
    localparam int BS   = 100;
    localparam int GP   = 20;

    logic clk;
    logic rst;

    pair_match_ctrl_if bus ();

    pair_match_ctrl #(
        .X_ORIGIN   (X0),
        .Y_ORIGIN   (Y0),
        .A_SIDE     (AS),
        .B_SIDE     (BS),
        .GAP        (GP),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Game-level reference model: face-up tiles kept as a queue of indices.
    bit [15:0] m_show;
    bit [15:0] m_matched;
    int        m_pairs;
    bit        m_prev;
    int        m_face[$];
    bit        m_check;
    int        m_hold_left;
    bit        m_done;

    typedef struct {
        bit          rst;
        bit          btn;
        int          x;
        int          y;
        logic [15:0] show;
        logic [15:0] matched;
        logic [3:0]  pairs;
        bit          mis;
        bit          done;
    } vec_t;

    vec_t vecs[$];

    function automatic int hit_tile(input int x, input int y);
        int cx = x - X0;
        int cy = y - Y0;
        if (cx < 0 || cy < 0) return -1;
        if (cx / (AS + GP) > 3 || cx % (AS + GP) > AS) return -1;
        if (cy / (BS + GP) > 3 || cy % (BS + GP) > BS) return -1;
        return (cy / (BS + GP)) * 4 + cx / (AS + GP);
    endfunction

    function automatic int tile_id(input int k);
        logic [47:0] ids = bus.pair_id;
        return int'((ids >> (3 * k)) & 48'd7);
    endfunction

    function automatic int center_x(input int t);
        return X0 + (t % 4) * (AS + GP) + AS / 2;
    endfunction

    function automatic int center_y(input int t);
        return Y0 + (t / 4) * (BS + GP) + BS / 2;
    endfunction

    task automatic model_step();
        bit c;
        int t;
        if (rst) begin
            m_show      = '0;
            m_matched   = '0;
            m_pairs     = 0;
            m_prev      = 1'b0;
            m_face.delete();
            m_check     = 1'b0;
            m_hold_left = 0;
            m_done      = 1'b0;
            return;
        end
        c      = bus.MouseLeft && !m_prev;
        m_prev = bus.MouseLeft;
        if (m_done) return;
        if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                foreach (m_face[i]) m_show[m_face[i]] = 1'b0;
                m_face.delete();
            end
        end else if (m_check) begin
            m_check = 1'b0;
            if (tile_id(m_face[0]) == tile_id(m_face[1])) begin
                foreach (m_face[i]) m_matched[m_face[i]] = 1'b1;
                m_pairs++;
                m_face.delete();
                if (m_pairs == 8) m_done = 1'b1;
            end else begin
                m_hold_left = HOLD;
            end
        end else if (c) begin
            t = hit_tile(int'(bus.xpos), int'(bus.ypos));
            if (t >= 0 && !m_show[t] && !m_matched[t]) begin
                m_show[t] = 1'b1;
                m_face.push_back(t);
                if (m_face.size() == 2) m_check = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit b, input int x, input int y);
        rst           = r;
        bus.MouseLeft = b;
        bus.xpos      = 12'(x);
        bus.ypos      = 12'(y);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] es, input logic [15:0] em,
                               input logic [3:0] ep, input bit emis, input bit edone);
        n_checks++;
        if (bus.show_mask !== es || bus.matched_mask !== em || bus.pairs_found !== ep ||
            bus.mismatch !== emis || bus.game_done !== edone) begin
            $display("[TB] FAIL %s: got show=%h matched=%h pairs=%0d mis=%b done=%b, want show=%h matched=%h pairs=%0d mis=%b done=%b",
                     name, bus.show_mask, bus.matched_mask, bus.pairs_found, bus.mismatch,
                     bus.game_done, es, em, ep, emis, edone);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_model(input string name);
        checkOutput(name, m_show, m_matched, 4'(m_pairs), m_hold_left > 0, m_done);
    endtask

    task automatic click_tile(input int t);
        applyStimulus(1'b0, 1'b1, center_x(t), center_y(t));
        applyStimulus(1'b0, 1'b0, center_x(t), center_y(t));
    endtask

    task automatic add_vec(input bit r, input bit b, input int x, input int y, input logic [15:0] s,
                           input logic [15:0] m, input logic [3:0] p, input bit mis, input bit d);
        vec_t v;
        v.rst = r; v.btn = b; v.x = x; v.y = y;
        v.show = s; v.matched = m; v.pairs = p; v.mis = mis; v.done = d;
        vecs.push_back(v);
    endtask

    logic [47:0] pa;
    logic [47:0] pr;
    int          ids[16];

    initial begin
        clk           = 1'b0;
        rst           = 1'b1;
        bus.MouseLeft = 1'b0;
        bus.xpos      = '0;
        bus.ypos      = '0;
        pa            = '0;
        for (int k = 0; k < 16; k++) pa[3*k +: 3] = 3'((k >> 1) + 3);
        bus.pair_id = pa;

        // Tile 0/1 share id 3; tile 4 (id 5) vs tile 6 (id 6) mismatch.
        add_vec(1, 0, 150, 150, 16'h0000, 16'h0000, 0, 0, 0);
        add_vec(0, 1, 150, 150, 16'h0001, 16'h0000, 0, 0, 0);
        add_vec(0, 0, 150, 150, 16'h0001, 16'h0000, 0, 0, 0);
        add_vec(0, 1, 150, 150, 16'h0001, 16'h0000, 0, 0, 0);
        add_vec(0, 0, 150, 150, 16'h0001, 16'h0000, 0, 0, 0);
        add_vec(0, 1,  99, 150, 16'h0001, 16'h0000, 0, 0, 0);
        add_vec(0, 0,  99, 150, 16'h0001, 16'h0000, 0, 0, 0);
        add_vec(0, 1, 210, 150, 16'h0001, 16'h0000, 0, 0, 0);
        add_vec(0, 0, 210, 150, 16'h0001, 16'h0000, 0, 0, 0);
        add_vec(0, 1, 270, 150, 16'h0003, 16'h0000, 0, 0, 0);
        add_vec(0, 0, 270, 150, 16'h0003, 16'h0003, 1, 0, 0);
        add_vec(0, 0, 270, 150, 16'h0003, 16'h0003, 1, 0, 0);
        add_vec(0, 1, 200, 270, 16'h0013, 16'h0003, 1, 0, 0);
        add_vec(0, 0, 200, 270, 16'h0013, 16'h0003, 1, 0, 0);
        add_vec(0, 1, 390, 270, 16'h0053, 16'h0003, 1, 0, 0);
        add_vec(0, 0, 390, 270, 16'h0053, 16'h0003, 1, 1, 0);
        add_vec(0, 1, 390, 150, 16'h0053, 16'h0003, 1, 1, 0);
        add_vec(0, 0, 390, 150, 16'h0053, 16'h0003, 1, 1, 0);
        add_vec(0, 0, 390, 150, 16'h0053, 16'h0003, 1, 1, 0);
        add_vec(0, 1, 390, 150, 16'h0003, 16'h0003, 1, 0, 0);
        add_vec(0, 1, 390, 150, 16'h0003, 16'h0003, 1, 0, 0);
        add_vec(0, 0, 390, 150, 16'h0003, 16'h0003, 1, 0, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].btn, vecs[i].x, vecs[i].y);
            checkOutput($sformatf("vec%0d", i), vecs[i].show, vecs[i].matched, vecs[i].pairs,
                        vecs[i].mis, vecs[i].done);
        end

        // Full game: every pair solved, then a click in DONE changes nothing.
        applyStimulus(1'b1, 1'b0, 0, 0);
        for (int p = 0; p < 8; p++) begin
            click_tile(2 * p);
            click_tile(2 * p + 1);
        end
        checkOutput("complete", 16'hFFFF, 16'hFFFF, 4'd8, 1'b0, 1'b1);
        click_tile(0);
        click_tile(5);
        checkOutput("done_click", 16'hFFFF, 16'hFFFF, 4'd8, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 0, 0);
        checkOutput("done_reset", 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);

        // Reset on the second HOLD cycle while the button is held down.
        click_tile(0);
        applyStimulus(1'b0, 1'b1, center_x(5), center_y(5));
        applyStimulus(1'b0, 1'b0, center_x(5), center_y(5));
        checkOutput("hold_enter", 16'h0021, 16'h0000, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, center_x(5), center_y(5));
        checkOutput("hold_second", 16'h0021, 16'h0000, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 150, 150);
        checkOutput("hold_reset", 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 150, 150);
        checkOutput("held_click", 16'h0001, 16'h0000, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 270, 150);
        checkOutput("held_no_repeat", 16'h0001, 16'h0000, 4'd0, 1'b0, 1'b0);

        // Randomized play against the model with shuffled pair layouts.
        for (int n = 0; n < 4000; n++) begin
            int t, off, x, y, j, tmp;
            bit r, b;
            if (n % 600 == 0) begin
                for (int k = 0; k < 16; k++) ids[k] = k >> 1;
                for (int k = 15; k > 0; k--) begin
                    j = $urandom_range(0, k);
                    tmp = ids[k]; ids[k] = ids[j]; ids[j] = tmp;
                end
                pr = '0;
                for (int k = 0; k < 16; k++) pr[3*k +: 3] = 3'(ids[k]);
                bus.pair_id = pr;
            end
            t = $urandom_range(0, 15);
            case ($urandom_range(0, 7))
                0: off = -1;
                1: off = 0;
                2: off = AS;
                3: off = AS + 1;
                default: off = $urandom_range(0, AS);
            endcase
            x = X0 + (t % 4) * (AS + GP) + off;
            y = Y0 + (t / 4) * (BS + GP) + (($urandom_range(0, 5) == 0) ? BS : BS / 2);
            if ($urandom_range(0, 19) == 0) x = $urandom_range(0, 700);
            b = ($urandom_range(0, 9) < 4) ? ~bus.MouseLeft : bus.MouseLeft;
            r = ($urandom_range(0, 499) == 0) || (m_done && $urandom_range(0, 9) == 0);
            applyStimulus(r, b, x, y);
            check_model($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
